div_arbiter: RTL
================

Name: div_arbiter

Overview:
- Shares one multi-cycle signed divider among NUM_REQ requesters, e.g. the qarctan instances of the mono/left/right demod paths.
- Arbitration is round-robin. The block captures the winner's operands, starts the divider, and returns the quotient to the winner.
- It sits between the qarctan blocks and the single divider instance, saving divider area in the FM radio datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, operand and quotient width (signed, Q10 fixed point handled by requesters)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request; hold high with operands stable until done[i]
- req_dividend  in  NUM_REQ*DATA_WIDTH  packed dividends, slice i belongs to requester i
- req_divisor  in  NUM_REQ*DATA_WIDTH  packed divisors
- done  out  NUM_REQ  one-hot, high one cycle when result belongs to requester i
- result  out  DATA_WIDTH  quotient, valid while any done bit is high
- div_zero  out  1  high with done when the granted divisor was 0
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  DATA_WIDTH  registered operand to divider
- div_divisor  out  DATA_WIDTH  registered operand to divider
- div_done  in  1  divider completion pulse
- div_quotient  in  DATA_WIDTH  divider quotient, valid with div_done

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, and sampled only on the rising edge of clk.
- Reset values: state=IDLE; all outputs 0; result=0; grant index=0; last-grant pointer=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the first asserted req searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register grant index, last_grant, and the winner's dividend and divisor into div_dividend and div_divisor.
  - If the winner's divisor==0: set result=0 and div_zero=1, and go to RETURN. The divider is not started.
  - Else go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold div_dividend and div_divisor stable.
  - On div_done=1, register result=div_quotient and go to RETURN.
  - With no div_done, wait indefinitely; there is no timeout.
- RETURN:
  - done[grant]=1 and result is stable for exactly one cycle; div_zero is as set in IDLE.
  - Next state is IDLE; div_zero clears on exit.
  - result holds its value until the next capture.
- Requester rule: deassert req[i] on the edge after observing done[i]. The arbiter does not sample req in RETURN, so a requester that deasserts on time is never double-granted.
- Latency:
  - Nonzero divisor: done occurs 3 cycles after the req edge plus the divider latency L (IDLE capture, ISSUE, L WAIT cycles, RETURN).
  - Zero divisor: done occurs 2 cycles after the capturing edge.
- Fairness: a requester holding req waits at most NUM_REQ-1 other transactions.
- Only one transaction is in flight; the arbiter is non-pipelined.
- Simultaneous new req and RETURN: the new req is evaluated in the following IDLE cycle.
- Operand changes by the winner after the capture edge are ignored.
- Operand changes by non-winners are ignored until their grant.
- Spurious div_done in IDLE, ISSUE or RETURN is ignored.
- div_done arriving in the same cycle as div_start (L=0) is not allowed; the divider guarantees L>=1.
- Reset mid-operation (any state): return to IDLE with reset values next cycle.
  - No done is issued for the aborted transaction.
  - A div_done arriving later is ignored.
- Width rules: operands and quotient are passed unmodified (signed, two's complement). The arbiter does no arithmetic beyond the zero-divisor compare.

Test Plan:
- Single requester: req[0]=1, dividend=32'h00000C00, divisor=32'h00000400, divider model L=5, quotient=3 -> one div_start, done[0] 8 cycles after the req edge, result=3, div_zero=0.
- Contention: req=2'b11 from reset, divider returns dividend/divisor -> grant order 0,1,0,1 across repeated requests; each done is one-hot and correct per requester's operands.
- Zero divisor: req[1]=1, divisor=0, dividend=32'hFFFFF000 -> no div_start, done[1] 2 cycles after capture, result=0, div_zero=1.
- Operand stability: change req_dividend[0] to 32'h7FFFFFFF during WAIT -> div_dividend unchanged, result uses the captured value.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT, then the model pulses div_done -> no done asserted, state IDLE, outputs 0. The next request completes normally.
- Starvation bound, NUM_REQ=4, all req held high: each requester is granted exactly once in every 4 consecutive transactions.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: shares one multi-cycle signed divider among NUM_REQ requesters.
// Round-robin arbitration picks a requester. The block captures the winner's
// operands and starts the divider, then returns the quotient with a one-cycle
// done pulse. A zero divisor is answered directly and the divider is not used.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   req                per-requester request, held until that requester's done
//   req_dividend       packed dividends, slice i belongs to requester i
//   req_divisor        packed divisors, slice i belongs to requester i
//   done               one-hot, high for one cycle for the served requester
//   result             quotient, valid while any done bit is high
//   div_zero           high with done when the granted divisor was 0
//   div_start          one-cycle start pulse to the divider
//   div_dividend       captured dividend presented to the divider
//   div_divisor        captured divisor presented to the divider
//   div_done           divider completion pulse
//   div_quotient       divider quotient, valid with div_done
module div_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]               done,
  output logic [DATA_WIDTH-1:0]            result,
  output logic                             div_zero,
  output logic                             div_start,
  output logic [DATA_WIDTH-1:0]            div_dividend,
  output logic [DATA_WIDTH-1:0]            div_divisor,
  input  logic                             div_done,
  input  logic [DATA_WIDTH-1:0]            div_quotient
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RETURN = 2'd3;

  logic [1:0]            state, state_d;
  logic [GW-1:0]         grant, grant_d;
  logic [GW-1:0]         last_grant, last_grant_d;
  logic [DATA_WIDTH-1:0] dividend_d, divisor_d, result_d;
  logic [NUM_REQ-1:0]    done_d;
  logic                  start_d, zero_d;

  logic [DATA_WIDTH-1:0] dvd_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] dvs_arr [NUM_REQ];
  logic [GW-1:0]         pick, cand;
  logic                  found;

  // Unpack the operand buses into per-requester words.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign dvd_arr[i] = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
    assign dvs_arr[i] = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first asserted req after last_grant, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = (last_grant == LAST_IDX) ? '0 : last_grant + GW'(1);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + GW'(1);
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    dividend_d   = div_dividend;
    divisor_d    = div_divisor;
    result_d     = result;
    zero_d       = div_zero;
    start_d      = 1'b0;
    done_d       = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_d      = pick;
          last_grant_d = pick;
          dividend_d   = dvd_arr[pick];
          divisor_d    = dvs_arr[pick];
          if (dvs_arr[pick] == '0) begin
            // Zero divisor is answered directly, without starting the divider.
            result_d = '0;
            zero_d   = 1'b1;
            done_d   = NUM_REQ'(1) << pick;
            state_d  = RETURN;
          end else begin
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          result_d = div_quotient;
          done_d   = NUM_REQ'(1) << grant;
          state_d  = RETURN;
        end
      end
      RETURN: begin
        zero_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LAST_IDX;
      div_dividend <= '0;
      div_divisor  <= '0;
      result       <= '0;
      div_zero     <= 1'b0;
      div_start    <= 1'b0;
      done         <= '0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      last_grant   <= last_grant_d;
      div_dividend <= dividend_d;
      div_divisor  <= divisor_d;
      result       <= result_d;
      div_zero     <= zero_d;
      div_start    <= start_d;
      done         <= done_d;
    end
  end

endmodule
